// File: rtl/bcd_timer_display.sv
// Stopwatch / reaction-timer core: packed-BCD elapsed-tick counter with
// start/stop/clear control, overflow handling and a multiplexed 7-segment scan.
module bcd_timer_display #(
  parameter int DIGITS      = 2,
  parameter int TICK_DIV    = 2_000_000,
  parameter int REFRESH_DIV = 4,
  parameter int WRAP        = 0,
  parameter int LZ_BLANK    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  hold,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  running,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   count
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, SAT = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [4*DIGITS-1:0] count_q, count_d, inc_s, disp_q;
  logic                ovf_q, ovf_d, all9_s, tick_s;
  logic [RW-1:0]       ref_q;
  logic [SW-1:0]       scan_q;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   dig_sel_q, dig_sel_d, shown_s;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  // Ripple-carry BCD increment; a carry out of the top digit means all-9s.
  always_comb begin
    logic carry;
    inc_s = count_q;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          inc_s[4*i +: 4] = 4'd0;
        end else begin
          inc_s[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end else begin
        inc_s[4*i +: 4] = count_q[4*i +: 4];
      end
    end
    all9_s = carry;
  end

  // Next-state logic; clear is applied last so it overrides any tick effect.
  always_comb begin
    tick_s  = (state_q == RUN) && (tick_q == TW'(TICK_DIV - 1)) && !stop && !clear;
    state_d = state_q;
    tick_d  = tick_q;
    count_d = count_q;
    ovf_d   = (WRAP != 0) ? 1'b0 : ovf_q;
    case (state_q)
      IDLE: begin
        if (start && !stop && !clear) begin
          state_d = RUN;
          tick_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (tick_s) begin
          tick_d = '0;
          if (all9_s) begin
            ovf_d = 1'b1;
            if (WRAP != 0) count_d = '0;
            else           state_d = SAT;
          end else begin
            count_d = inc_s;
          end
        end else if (!clear) begin
          tick_d = tick_q + TW'(1);
        end else begin
          tick_d = '0;
        end
      end
      SAT: begin
        if (clear) state_d = IDLE;
        else       state_d = SAT;
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      count_d = '0;
      tick_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      ovf_d = ovf_d;
    end
  end

  // Control state, tick phase, count and overflow registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Display latch and free-running digit scan.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_q <= '0;
      ref_q  <= '0;
      scan_q <= '0;
    end else begin
      if (!hold) disp_q <= count_q;
      if (ref_q == RW'(REFRESH_DIV - 1)) begin
        ref_q  <= '0;
        scan_q <= (scan_q == SW'(DIGITS - 1)) ? '0 : scan_q + SW'(1);
      end else begin
        ref_q <= ref_q + RW'(1);
      end
    end
  end

  // A digit is shown if it or any more-significant latched digit is non-zero.
  always_comb begin
    logic above;
    above   = 1'b0;
    shown_s = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      above      = above | (disp_q[4*k +: 4] != 4'd0);
      shown_s[k] = above || (k == 0) || (LZ_BLANK == 0);
    end
  end

  // Segment and digit-select values for the digit currently indexed.
  always_comb begin
    dig_sel_d = DIGITS'(1) << scan_q;
    if (blank || !shown_s[scan_q]) seg_d = 7'b0000000;
    else                           seg_d = seg7(disp_q[4*int'(scan_q) +: 4]);
  end

  // Output registers so seg and dig_sel change on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q     <= 7'b0000000;
      dig_sel_q <= DIGITS'(1);
    end else begin
      seg_q     <= seg_d;
      dig_sel_q <= dig_sel_d;
    end
  end

  assign seg     = seg_q;
  assign dig_sel = dig_sel_q;
  assign running = (state_q == RUN);
  assign ovf     = ovf_q;
  assign count   = count_q;

endmodule

// File: tb/tb_bcd_timer_display.sv
// Self-checking bench: two instances (saturating and wrapping) driven in
// lockstep and compared every cycle against an integer-valued timer model.
module tb_bcd_timer_display;

  localparam int TD = 4;
  localparam int RD = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_SAT = 2;

  logic clk = 1'b0, reset = 1'b1;
  logic start = 1'b0, stop = 1'b0, clear = 1'b0, hold = 1'b0, blank = 1'b0;
  logic [6:0] seg0, seg1;
  logic [1:0] dsel0, dsel1;
  logic run0, run1, ovf0, ovf1;
  logic [7:0] cnt0, cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] enc_t [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                             7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  int m_cnt [2], m_mode [2], m_tick [2], m_latch [2];
  logic m_ovf [2];
  logic [6:0] m_seg [2];
  logic [1:0] m_dsel;
  int m_scan, m_ref;

  bcd_timer_display #(.DIGITS(2), .TICK_DIV(TD), .REFRESH_DIV(RD), .WRAP(0), .LZ_BLANK(1)) u_sat (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .hold(hold),
    .blank(blank), .seg(seg0), .dig_sel(dsel0), .running(run0), .ovf(ovf0), .count(cnt0));

  bcd_timer_display #(.DIGITS(2), .TICK_DIV(TD), .REFRESH_DIV(RD), .WRAP(1), .LZ_BLANK(1)) u_wrap (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .hold(hold),
    .blank(blank), .seg(seg1), .dig_sel(dsel1), .running(run1), .ovf(ovf1), .count(cnt1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_cnt[w] = 0; m_mode[w] = M_IDLE; m_tick[w] = 0; m_latch[w] = 0;
      m_ovf[w] = 1'b0; m_seg[w] = 7'b0000000;
    end
    m_dsel = 2'b01; m_scan = 0; m_ref = 0;
  endtask

  // One clock edge of the timer behaviour; w==1 is the wrapping instance.
  task automatic model_edge(input logic st, input logic sp, input logic cl, input logic hd, input logic bk);
    for (int w = 0; w < 2; w++) begin
      int d;
      logic on;
      d  = (m_scan == 0) ? m_latch[w] % 10 : m_latch[w] / 10;
      on = (m_scan == 0) || (m_latch[w] >= 10);
      m_seg[w] = (bk || !on) ? 7'b0000000 : enc_t[d];
      if (!hd) m_latch[w] = m_cnt[w];
      if (w == 1) m_ovf[w] = 1'b0;
      if (m_mode[w] == M_RUN) begin
        if (sp) m_mode[w] = M_IDLE;
        else if (!cl) begin
          if (m_tick[w] == TD - 1) begin
            m_tick[w] = 0;
            if (m_cnt[w] == 99) begin
              m_ovf[w] = 1'b1;
              if (w == 1) m_cnt[w] = 0;
              else        m_mode[w] = M_SAT;
            end else m_cnt[w] = m_cnt[w] + 1;
          end else m_tick[w] = m_tick[w] + 1;
        end
      end else if (m_mode[w] == M_IDLE) begin
        if (st && !sp && !cl) begin m_mode[w] = M_RUN; m_tick[w] = 0; end
      end else if (cl) m_mode[w] = M_IDLE;
      if (cl) begin m_cnt[w] = 0; m_tick[w] = 0; m_ovf[w] = 1'b0; end
    end
    m_dsel = 2'b01 << m_scan;
    if (m_ref == RD - 1) begin m_ref = 0; m_scan = (m_scan + 1) % 2; end
    else m_ref = m_ref + 1;
  endtask

  task automatic check_model();
    chk("model_sat  {cnt,run,ovf,seg,dsel}", {cnt0, run0, ovf0, seg0, dsel0},
        {bcd(m_cnt[0]), m_mode[0] == M_RUN, m_ovf[0], m_seg[0], m_dsel});
    chk("model_wrap {cnt,run,ovf,seg,dsel}", {cnt1, run1, ovf1, seg1, dsel1},
        {bcd(m_cnt[1]), m_mode[1] == M_RUN, m_ovf[1], m_seg[1], m_dsel});
  endtask

  task automatic step(input logic st, input logic sp, input logic cl, input logic hd, input logic bk);
    start = st; stop = sp; clear = cl; hold = hd; blank = bk;
    @(posedge clk);
    model_edge(st, sp, cl, hd, bk);
    #1;
    check_model();
  endtask

  task automatic idle(input int n, input logic hd);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, hd, 1'b0);
  endtask

  // Observe one full scan of the saturating instance.
  task automatic capture(input logic hd, input logic bk, output logic [6:0] d0, output logic [6:0] d1,
                         output logic saw0, output logic saw1);
    d0 = 7'h7f; d1 = 7'h7f; saw0 = 1'b0; saw1 = 1'b0;
    for (int i = 0; i < 2 * RD; i++) begin
      step(1'b0, 1'b0, 1'b0, hd, bk);
      if (dsel0 == 2'b01) begin d0 = seg0; saw0 = 1'b1; end
      else if (dsel0 == 2'b10) begin d1 = seg0; saw1 = 1'b1; end
    end
  endtask

  typedef struct {
    logic st, sp, cl;
    int   cycles;
    logic [7:0] exp_cnt;
    logic exp_run;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [6:0] d0, d1;
    logic saw0, saw1;
    logic st, sp, cl, hd, bk;

    tbl[0] = '{1'b1, 1'b0, 1'b0,  1, 8'h00, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 1'b0,  3, 8'h00, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 1'b0,  1, 8'h01, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 36, 8'h10, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b0,  1, 8'h10, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 10, 8'h10, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0,  1, 8'h10, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b0,  4, 8'h11, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 1'b1,  1, 8'h00, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b0,  2, 8'h00, 1'b0};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    chk("reset count", cnt0, 8'h00);
    chk("reset running", run0, 1'b0);
    chk("reset ovf", ovf0, 1'b0);
    chk("reset dig_sel", dsel0, 2'b01);
    chk("reset seg", seg0, 7'b0000000);
    check_model();

    for (int v = 0; v < 10; v++) begin
      step(tbl[v].st, tbl[v].sp, tbl[v].cl, 1'b0, 1'b0);
      idle(tbl[v].cycles - 1, 1'b0);
      chk($sformatf("vec%0d count", v), cnt0, tbl[v].exp_cnt);
      chk($sformatf("vec%0d running", v), run0, tbl[v].exp_run);
    end

    // Run both instances to overflow.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(399, 1'b0);
    chk("pre-ovf count", cnt0, 8'h99);
    idle(1, 1'b0);
    chk("sat count", cnt0, 8'h99);
    chk("sat ovf", ovf0, 1'b1);
    chk("sat running", run0, 1'b0);
    chk("wrap count", cnt1, 8'h00);
    chk("wrap ovf", ovf1, 1'b1);
    chk("wrap running", run1, 1'b1);
    idle(1, 1'b0);
    chk("wrap ovf pulse end", ovf1, 1'b0);
    chk("sat ovf held", ovf0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat start ignored run", run0, 1'b0);
    chk("sat start ignored count", cnt0, 8'h99);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("sat clear count", cnt0, 8'h00);
    chk("sat clear ovf", ovf0, 1'b0);
    chk("sat clear running", run0, 1'b0);

    // Hold freezes the display at 05 while counting to 13.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(21, 1'b0);
    idle(31, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("hold count", cnt0, 8'h13);
    capture(1'b1, 1'b0, d0, d1, saw0, saw1);
    chk("hold digit0", d0, 7'b1101101);
    chk("hold digit1", d1, 7'b0000000);
    idle(2, 1'b0);
    capture(1'b0, 1'b0, d0, d1, saw0, saw1);
    chk("release digit0", d0, 7'b1001111);
    chk("release digit1", d1, 7'b0000110);

    // Leading-zero blanking at 07, then forced blank.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(28, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lz count", cnt0, 8'h07);
    idle(2, 1'b0);
    capture(1'b0, 1'b0, d0, d1, saw0, saw1);
    chk("lz digit0", d0, 7'b0000111);
    chk("lz digit1", d1, 7'b0000000);
    capture(1'b0, 1'b1, d0, d1, saw0, saw1);
    chk("blank digit0", d0, 7'b0000000);
    chk("blank digit1", d1, 7'b0000000);
    chk("blank scan continues", {saw1, saw0}, 2'b11);

    // Asynchronous reset mid-run.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(10, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("async reset count", cnt0, 8'h00);
    chk("async reset running", run0, 1'b0);
    chk("async reset dig_sel", dsel0, 2'b01);
    chk("async reset seg", seg0, 7'b0000000);
    chk("async reset wrap", {cnt1, run1, ovf1, seg1, dsel1}, {8'h00, 1'b0, 1'b0, 7'b0000000, 2'b01});
    #2 reset = 1'b0;
    model_reset();

    // Randomised traffic against the model.
    hd = 1'b0; bk = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom_range(7) == 0);
      sp = ($urandom_range(15) == 0);
      cl = ($urandom_range(63) == 0);
      if ($urandom_range(15) == 0) hd = ~hd;
      if ($urandom_range(15) == 0) bk = ~bk;
      step(st, sp, cl, hd, bk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_timer_display.md
# bcd_timer_display

Parametrised stopwatch/reaction-timer core with a built-in multiplexed seven-segment driver. It is the generalised successor to the fixed two-digit game display. It counts elapsed ticks in packed BCD across `DIGITS` digits, with start/stop/clear control, a selectable overflow mode, lap-hold and leading-zero blanking. It scans the digits onto one shared segment bus and sits between the game FSM (control pulses) and the `uo_out` pins (`seg`, `dig_sel`).

## Interface
- `DIGITS`, 2: number of BCD digits, legal 1..8; digit 0 is least significant.
- `TICK_DIV`, 2_000_000: `clk` cycles per count increment, ≥2.
- `REFRESH_DIV`, 4: `clk` cycles each digit stays selected, ≥1.
- `WRAP`, 0: 0 = saturate at all-9s; 1 = wrap to all-0s.
- `LZ_BLANK`, 1: 1 = blank leading zeros; digit 0 is always shown.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle pulse, begin counting.
- `stop`  in  1  one-cycle pulse, pause counting.
- `clear`  in  1  one-cycle pulse, zero the count.
- `hold`  in  1  level; freeze the displayed value while counting continues.
- `blank`  in  1  level; force `seg` to all-off.
- `seg`  out  7  segment pattern `{g,f,e,d,c,b,a}`, active-high.
- `dig_sel`  out  DIGITS  one-hot digit enable.
- `running`  out  1  high while in RUN.
- `ovf`  out  1  overflow indication (meaning depends on `WRAP`).
- `count`  out  4*DIGITS  live packed-BCD count.

## Operation
- FSM states: IDLE, RUN, SAT. Reset state is IDLE.
- IDLE: `start` → RUN, and the tick counter is zeroed.
- RUN: `stop` → IDLE. A tick at all-9s with `WRAP`=0 → SAT.
- SAT: `clear` → IDLE. `start` and `stop` are ignored.
- Control priority within one cycle: `clear` > `stop` > `start`.
- `start` while already in RUN is ignored; the tick phase is not disturbed.
- `clear` zeroes the count and the tick counter and drops `ovf`. It leaves the state unchanged except SAT→IDLE. `clear` beats a coincident tick.
- Tick counter runs 0..TICK_DIV-1, only in RUN; a tick fires on the cycle it equals TICK_DIV-1, then it returns to 0.
- On a tick the count increments as BCD with ripple carry (9→0, +1 to the next digit). Digit values are always 0..9.
- Overflow with `WRAP`=1: all-9s → all-0s, `ovf` high for exactly that one cycle, stays in RUN.
- Overflow with `WRAP`=0: count stays all-9s, enters SAT, `ovf` held high until `clear` or reset.
- Display latch loads `count` every cycle while `hold`=0 and is frozen while `hold`=1.
- Leading-zero blanking: digit k>0 is blank when it and every more-significant digit of the latch are 0.
- Refresh: a free-running counter 0..REFRESH_DIV-1. On its wrap the scan index advances 0→DIGITS-1→0. The scan runs in every state, regardless of `blank` and `hold`.
- Encoding 0–9: 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1101111. A blanked digit is 0000000.

## Timing
- Reset values: count 0, `running` 0, `ovf` 0, state IDLE, scan index 0, `dig_sel` = 1 (digit 0), `seg` 0000000, display latch 0, tick and refresh counters 0.
- `seg` and `dig_sel` are registered from the same scan index every cycle. They always change on the same edge, one cycle after the index changes.
- `start` sampled at edge N: `running`=1 after N. First increment is visible on `count` after edge N+TICK_DIV.
- `stop` at edge N: `running`=0 after N. A tick due at N is suppressed. The tick phase is kept, so a later `start` re-zeroes it.
- Latency `count`→`seg`: 2 cycles (latch, then segment register), when that digit is being scanned.
- `ovf` rises on the same edge the wrap or saturation is applied to `count`.
- `reset` asserted mid-run: all registers return to reset values immediately (asynchronous). Operation resumes on the first edge after deassertion.

## Test plan
- DIGITS=2, TICK_DIV=4, REFRESH_DIV=2: pulse `start` → `running`=1, `count` 0x01 exactly 4 cycles later, 0x10 after 40 cycles. `dig_sel` alternates 01/10 every 2 cycles.
- WRAP=0, run to 0x99, next tick → `count` stays 0x99, `ovf`=1, `running`=0. `start` is ignored. `clear` → 0x00, `ovf`=0, IDLE.
- WRAP=1, from 0x99 a tick → 0x00, `ovf` is a one-cycle pulse, `running` stays 1.
- At 0x05 raise `hold`, run 8 ticks (`count`=0x13): `seg` shows digit1 blank and digit0 1101101. Drop `hold` → within 2 cycles digit1 0000110 and digit0 1001111.
- Count 0x07, LZ_BLANK=1 → digit1 0000000, digit0 0000111. `blank`=1 → `seg` 0000000 while `dig_sel` keeps scanning.
- `clear`+`stop`+`start` in the same cycle while in RUN → count 0, state IDLE. `reset` pulse mid-run → all outputs at reset values before the next edge.
